mem_port_arbiter: RTL and testbench

- Shares the single SRAM-like memory bus between instruction fetch (F stage) and data access (M stage).
- Grants one requester at a time and latches its request into bus registers.
- Sequences the address and data phases, then routes the response back to the owner.
- Data requests win by default, so memory instructions in M are never starved by fetch; the core's stall logic consumes the per-side handshakes.

---
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one SRAM-like memory bus between instruction fetch and data access.
//   One transaction in flight at a time: IDLE grants a requester and latches its
//   request into the bus registers, ADDR presents the address phase, WAIT holds
//   until the response arrives, which is routed back to the owning side.
//
//   Optional feature (macro MEM_ARB_RR_EN):
//     defined   - round-robin on a simultaneous inst/data request in IDLE
//                 (the side not granted last wins; data wins the first tie).
//     undefined - fixed data-over-inst priority.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   inst_req/addr/cancel      fetch request side (cancel discards the response)
//   inst_addr_ok/data_ok/rdata  fetch handshakes and read data
//   data_req/wr/size/addr/wdata data request side
//   data_addr_ok/data_ok/rdata  data handshakes and load data
//   bus_req/wr/size/addr/wdata  memory bus request (registered fields)
//   bus_addr_ok/data_ok/rdata   memory bus handshakes and read data
//   busy                      a transaction is in flight

module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_cancel,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,

    output logic              busy
);

    typedef enum logic [1:0] {StIdle, StAddr, StWait} stateT;

    localparam logic OwnInst = 1'b0;
    localparam logic OwnData = 1'b1;

    stateT stateQ;
    logic  ownerQ;
    logic  cancelPendQ;

    logic  grantData;
    logic  grantInst;
    logic  inIdle;
    logic  deliver;

`ifdef MEM_ARB_RR_EN
    logic  lastGrantQ;
`endif

    always_comb begin
`ifdef MEM_ARB_RR_EN
        // On a tie, the side that did not win last time goes first.
        grantData = data_req && (!inst_req || (lastGrantQ == OwnInst));
`else
        grantData = data_req;
`endif
        grantInst = inst_req && !grantData;

        // rst gating keeps the combinational addr_ok low while reset is held.
        inIdle       = rst && (stateQ == StIdle);
        inst_addr_ok = inIdle && grantInst;
        data_addr_ok = inIdle && grantData;

        // A response counts in ADDR only when the address is accepted the same cycle.
        deliver = ((stateQ == StAddr) && bus_addr_ok && bus_data_ok) ||
                  ((stateQ == StWait) && bus_data_ok);

        // A cancel arriving with the response suppresses it as well.
        inst_data_ok = deliver && (ownerQ == OwnInst) && !cancelPendQ && !inst_cancel;
        data_data_ok = deliver && (ownerQ == OwnData);
        inst_rdata   = inst_data_ok ? bus_rdata : '0;
        data_rdata   = data_data_ok ? bus_rdata : '0;

        bus_req = (stateQ == StAddr);
        busy    = (stateQ != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ      <= StIdle;
            ownerQ      <= OwnInst;
            cancelPendQ <= 1'b0;
            bus_wr      <= 1'b0;
            bus_size    <= 2'd0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
`ifdef MEM_ARB_RR_EN
            lastGrantQ  <= OwnInst;
`endif
        end else begin
            // Cancel only matters for an inst transaction already on the bus.
            if (stateQ != StIdle && ownerQ == OwnInst && inst_cancel) begin
                cancelPendQ <= 1'b1;
            end

            case (stateQ)
                StIdle: begin
                    if (grantData) begin
                        ownerQ    <= OwnData;
                        bus_wr    <= data_wr;
                        bus_size  <= data_size;
                        bus_addr  <= data_addr;
                        bus_wdata <= data_wdata;
                        stateQ    <= StAddr;
`ifdef MEM_ARB_RR_EN
                        lastGrantQ <= OwnData;
`endif
                    end else if (grantInst) begin
                        ownerQ    <= OwnInst;
                        bus_wr    <= 1'b0;
                        bus_size  <= 2'd2;
                        bus_addr  <= inst_addr;
                        bus_wdata <= '0;
                        stateQ    <= StAddr;
`ifdef MEM_ARB_RR_EN
                        lastGrantQ <= OwnInst;
`endif
                    end
                end
                StAddr: begin
                    if (bus_addr_ok) begin
                        if (bus_data_ok) begin
                            stateQ      <= StIdle;
                            cancelPendQ <= 1'b0;
                        end else begin
                            stateQ <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (bus_data_ok) begin
                        stateQ      <= StIdle;
                        cancelPendQ <= 1'b0;
                    end
                end
                default: begin
                    stateQ      <= StIdle;
                    cancelPendQ <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic        inst_cancel = 1'b0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [1:0]  data_size = 2'd0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        bus_req, bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_addr_ok = 1'b0;
    logic        bus_data_ok = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        busy;

    int totalCnt = 0;
    int passCnt  = 0;

    typedef struct {
        logic        isInst;
        logic [31:0] rdata;
    } expT;
    expT sb[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Drive point: just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check point: falling edge, away from the active edge.
    task automatic mid();
        @(negedge clk);
    endtask

    // Scoreboard: every *_data_ok pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (inst_data_ok || data_data_ok) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
            end else begin
                expT e;
                e = sb.pop_front();
                chk("resp_side", {30'd0, inst_data_ok, data_data_ok},
                    e.isInst ? 32'd2 : 32'd1);
                chk("resp_rdata", e.isInst ? inst_rdata : data_rdata, e.rdata);
                chk("resp_other_rdata", e.isInst ? data_rdata : inst_rdata, 32'd0);
            end
        end
    end

    initial begin
        // Reset state
        mid();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_bus_req", {31'd0, bus_req}, 0);
        chk("rst_bus_fields", {bus_wr, bus_size, bus_addr[28:0]}, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        tick();
        rst = 1'b1;

        // Inst only fetch
        tick();
        inst_req = 1'b1; inst_addr = 32'hBFC00000;
        mid();
        chk("i_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
        chk("i_busy_grant", {31'd0, busy}, 0);
        sb.push_back('{isInst: 1'b1, rdata: 32'h3C080001});
        tick();
        inst_req = 1'b0; bus_addr_ok = 1'b1;
        mid();
        chk("i_bus_req", {31'd0, bus_req}, 1);
        chk("i_bus_addr", bus_addr, 32'hBFC00000);
        chk("i_bus_wr_size", {29'd0, bus_wr, bus_size}, 32'd2);
        chk("i_addr_ok_low", {31'd0, inst_addr_ok}, 0);
        tick();
        bus_addr_ok = 1'b0;
        mid();
        chk("i_wait_bus_req", {31'd0, bus_req}, 0);
        chk("i_wait_busy", {31'd0, busy}, 1);
        tick();
        bus_data_ok = 1'b1; bus_rdata = 32'h3C080001;
        mid();
        chk("i_data_ok", {31'd0, inst_data_ok}, 1);
        tick();
        bus_data_ok = 1'b0; bus_rdata = '0;
        mid();
        chk("i_busy_fall", {31'd0, busy}, 0);

        // Simultaneous requests: data store first, then inst
        tick();
        inst_req = 1'b1; inst_addr = 32'hBFC00004;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
        data_addr = 32'h80001000; data_wdata = 32'hDEADBEEF;
        mid();
        chk("s_grant", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
        sb.push_back('{isInst: 1'b0, rdata: 32'h0});
        tick();
        data_req = 1'b0; bus_addr_ok = 1'b1;
        mid();
        chk("s_bus_wr", {31'd0, bus_wr}, 1);
        chk("s_bus_wdata", bus_wdata, 32'hDEADBEEF);
        chk("s_bus_addr", bus_addr, 32'h80001000);
        chk("s_inst_held", {31'd0, inst_addr_ok}, 0);
        tick();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
        mid();
        chk("s_data_ok", {31'd0, data_data_ok}, 1);
        chk("s_inst_wait", {31'd0, inst_addr_ok}, 0);
        tick();
        bus_data_ok = 1'b0;
        mid();
        chk("s_inst_grant", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
        sb.push_back('{isInst: 1'b1, rdata: 32'h11112222});
        tick();
        inst_req = 1'b0; bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h11112222;
        mid();
        chk("s_inst_bus_cfg", {bus_wr, bus_size, bus_wdata[28:0]}, 32'h40000000);

        // Same-cycle ack on a data load
        tick();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80002000;
        mid();
        chk("l_addr_ok", {31'd0, data_addr_ok}, 1);
        sb.push_back('{isInst: 1'b0, rdata: 32'h12345678});
        tick();
        data_req = 1'b0; bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h12345678;
        mid();
        chk("l_data_ok", {31'd0, data_data_ok}, 1);
        tick();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
        mid();
        chk("l_idle_next", {31'd0, busy}, 0);

        // Cancel during WAIT; data_req during WAIT waits for IDLE
        tick();
        inst_req = 1'b1; inst_addr = 32'hBFC00008;
        mid();
        chk("c_addr_ok", {31'd0, inst_addr_ok}, 1);
        tick();
        inst_req = 1'b0; bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0; inst_cancel = 1'b1;
        tick();
        inst_cancel = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hAAAA5555;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h80003000;
        mid();
        chk("c_suppressed", {31'd0, inst_data_ok}, 0);
        chk("c_data_blocked", {31'd0, data_addr_ok}, 0);
        tick();
        bus_data_ok = 1'b0; bus_rdata = '0;
        mid();
        chk("c_data_grant", {31'd0, data_addr_ok}, 1);
        sb.push_back('{isInst: 1'b0, rdata: 32'h0BADF00D});
        tick();
        data_req = 1'b0; bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h0BADF00D;
        mid();
        chk("c_data_ok", {31'd0, data_data_ok}, 1);

        // Stray bus handshakes in IDLE are ignored
        tick();
        bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h55555555;
        mid();
        chk("x_idle_oks", {30'd0, inst_data_ok, data_data_ok}, 0);
        tick();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
        mid();
        chk("x_idle_busy", {31'd0, busy}, 0);

        // Cancel arriving with the response; cancel_pend must not leak to next fetch
        tick();
        inst_req = 1'b1; inst_addr = 32'hBFC0000C;
        tick();
        inst_req = 1'b0; bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1; inst_cancel = 1'b1;
        mid();
        chk("k_same_cycle", {31'd0, inst_data_ok}, 0);
        tick();
        bus_data_ok = 1'b0; inst_cancel = 1'b0;
        inst_req = 1'b1; inst_addr = 32'hBFC00010;
        mid();
        chk("k_regrant", {31'd0, inst_addr_ok}, 1);
        sb.push_back('{isInst: 1'b1, rdata: 32'h24020001});
        tick();
        inst_req = 1'b0; bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h24020001;
        mid();
        chk("k_fresh_ok", {31'd0, inst_data_ok}, 1);

        // Reset in WAIT drops the access
        tick();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
        inst_req = 1'b1; inst_addr = 32'hBFC00014;
        tick();
        inst_req = 1'b0; bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("r_busy", {31'd0, busy}, 0);
        chk("r_bus_req", {31'd0, bus_req}, 0);
        chk("r_bus_addr", bus_addr, 0);
        tick();
        bus_data_ok = 1'b1; bus_rdata = 32'h77777777;
        mid();
        chk("r_no_data_ok", {30'd0, inst_data_ok, data_data_ok}, 0);
        tick();
        rst = 1'b1;
        mid();
        chk("r_after_release", {29'd0, inst_data_ok, data_data_ok, busy}, 0);
        tick();
        bus_data_ok = 1'b0; bus_rdata = '0;

        // Byte store held stable until bus_addr_ok
        tick();
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
        data_addr = 32'h80000003; data_wdata = 32'h000000A5;
        mid();
        chk("b_addr_ok", {31'd0, data_addr_ok}, 1);
        sb.push_back('{isInst: 1'b0, rdata: 32'h0});
        tick();
        data_req = 1'b0;
        mid();
        chk("b_size", {30'd0, bus_size}, 0);
        chk("b_addr", bus_addr, 32'h80000003);
        tick();
        data_addr = 32'h12340000; data_size = 2'd2;
        mid();
        chk("b_addr_stable", bus_addr, 32'h80000003);
        chk("b_req_stable", {29'd0, bus_req, bus_size}, 32'd4);
        tick();
        bus_addr_ok = 1'b1;
        tick();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b1;
        mid();
        chk("b_data_ok", {31'd0, data_data_ok}, 1);
        tick();
        bus_data_ok = 1'b0;

        tick();
        tick();
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
